rr_arbiter4: RTL
================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter HOLD_MAX, default 8, is the maximum number of consecutive cycles one grant may be held before it is forcibly released (legal range 1..255).
REQ-002 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, is the reset; asynchronous, active-low.
REQ-004 Port req, input, 4, holds the request lines; bit i is requester i's request.
REQ-005 Port done, input, 1, is asserted by the current grant holder for one cycle to release the resource.
REQ-006 Port gnt, output, 4, is the one-hot grant, or all zeros when no grant is active.
REQ-007 Port gnt_idx, output, 2, is the binary index of the granted requester (4-to-2 encoding of gnt); it is 0 when no grant is active.
REQ-008 Port gnt_vld, output, 1, is high exactly when gnt is nonzero.
REQ-009 Port timeout, output, 1, is a one-cycle pulse when a grant is forcibly released at HOLD_MAX.

Function
REQ-010 Two-state FSM: IDLE, GRANT; all outputs SHALL be registered.
REQ-011 IDLE with req==0: remain IDLE; gnt, gnt_idx, gnt_vld stay 0.
REQ-012 IDLE with req!=0 at a rising edge: winner = first set bit of req, searching upward from ptr with wrap 3->0; from that edge gnt=one-hot(winner), gnt_idx=winner, gnt_vld=1, state=GRANT (latency: 1 edge from sampled request).
REQ-013 On each grant, ptr SHALL be loaded with (winner+1) mod 4, a 2-bit wrap; ptr SHALL be unchanged otherwise.
REQ-014 In GRANT, the hold counter SHALL count cycles in GRANT, starting at 1 on the grant edge and saturating at HOLD_MAX.
REQ-015 Release from GRANT occurs at the edge where any of these holds: done==1, req[gnt_idx]==0, or hold counter==HOLD_MAX.
REQ-016 On release: state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, hold counter=0; a mandatory single idle cycle follows, so there is no back-to-back grant.
REQ-017 timeout SHALL pulse for one cycle coincident with a release caused only by the counter; done or a request drop at the same edge suppresses timeout.
REQ-018 Requests from non-holders during GRANT SHALL be ignored; they are not latched and are re-sampled in IDLE.
REQ-019 done asserted while in IDLE SHALL have no effect.
REQ-020 With HOLD_MAX=1, every grant SHALL last exactly one cycle, with timeout pulsed unless done or a request drop occurs.

Reset
REQ-021 rst_n low SHALL immediately force: state=IDLE, ptr=0, hold counter=0, gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
REQ-022 Reset asserted mid-grant SHALL drop the grant asynchronously without a timeout pulse; after deassertion, arbitration restarts from ptr=0.
REQ-023 The first rising edge after rst_n rises SHALL be a normal IDLE evaluation.

Structure
REQ-024 The shared package arb_pkg SHALL hold the FSM state encoding (IDLE=0, GRANT=1), the requester count NREQ=4 and the index width IDXW=2.
REQ-025 One sub-module, rr_pick4, is natural: combinational rotate-priority select from (req, ptr) to a one-hot winner plus a 2-bit index (the encoder function).
REQ-026 The hold counter width SHALL be 8 bits.

Verification
REQ-027 After reset, req=4'b1111: grants SHALL occur in order idx 0,1,2,3,0 with each holder pulsing done after 2 cycles; every grant lasts 2 cycles and each is separated by 1 idle cycle.
REQ-028 ptr=2 (after granting idx 1), req=4'b0011: the next grant SHALL go to idx 0 (wrap search 2->3->0), gnt=4'b0001.
REQ-029 HOLD_MAX=3, req=4'b0100 held with no done: gnt=4'b0100 for 3 cycles, timeout pulses on the 3rd release edge, then 1 idle cycle, then re-grant to idx 2.
REQ-030 Grant to idx 1, holder drops req[1] while req[3]=1: release at the next edge, 1 idle cycle, then gnt=4'b1000, gnt_idx=3.
REQ-031 rst_n pulsed low mid-grant at a non-edge time: outputs SHALL go to 0 immediately, timeout=0, and the next grant with req=4'b1010 SHALL be idx 1.
REQ-032 done and counter==HOLD_MAX on the same edge: release SHALL occur with timeout=0; gnt_vld SHALL equal |gnt and gnt_idx SHALL equal encode(gnt) on every cycle of the run.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Holds FSM encoding, requester count, index width and a 4:2 encoder.
package arb_pkg;

  localparam int NREQ = 4;
  localparam int IDXW = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [IDXW-1:0] enc4(
    input logic [NREQ-1:0] oh
  );
    logic [IDXW-1:0] r;
    r = '0;
    unique case (1'b1)
      oh[0]:   r = 2'd0;
      oh[1]:   r = 2'd1;
      oh[2]:   r = 2'd2;
      oh[3]:   r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters and the arbiter.
// master: requester side (req, done out); slave: arbiter side (grant out).
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_vld;
  logic            timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_vld, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_vld, timeout
  );

endinterface

// File: rtl/rr_pick4.sv
// Rotate-priority select: first set req bit at or above ptr, wrapping.
// Ports: req, ptr in; win (one-hot or 0), idx (binary of win) out.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] win,
  output logic [IDXW-1:0] idx
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] sh;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   pri;

  always_comb begin
    dbl = {req, req};
    // rot[k] = req[(ptr+k) mod 4]
    rot = dbl[ptr +: NREQ];
    // isolate lowest set bit of the rotated vector
    pri = rot & (~rot + 4'd1);
    // rotate back: win[j] = pri[(j-ptr) mod 4]
    sh  = {pri, pri} << ptr;
    win = sh[2*NREQ-1 -: NREQ];
    idx = enc4(win);
  end

endmodule

// File: rtl/rr_arbiter4.sv
// 4-way round-robin arbiter with done release and hold-time limit.
// Ports: clk, rst_n (async low), bus (slave: req/done in, gnt/idx/vld/timeout out).
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave bus
);

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [7:0]      hold;
  logic [NREQ-1:0] win;
  logic [IDXW-1:0] widx;
  logic            held;
  logic            at_max;
  logic            rel;

  rr_pick4 u_pick (
    .req (bus.req),
    .ptr (ptr),
    .win (win),
    .idx (widx)
  );

  always_comb begin
    held   = bus.req[bus.gnt_idx];
    at_max = (hold == 8'(HOLD_MAX));
    rel    = bus.done | ~held | at_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold        <= '0;
      bus.gnt     <= '0;
      bus.gnt_idx <= '0;
      bus.gnt_vld <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.timeout <= 1'b0;
          if (|bus.req) begin
            state       <= GRANT;
            bus.gnt     <= win;
            bus.gnt_idx <= widx;
            bus.gnt_vld <= 1'b1;
            ptr         <= widx + 2'd1;
            hold        <= 8'd1;
          end
        end
        GRANT: begin
          if (rel) begin
            state       <= IDLE;
            bus.gnt     <= '0;
            bus.gnt_idx <= '0;
            bus.gnt_vld <= 1'b0;
            hold        <= '0;
            // only a pure counter expiry reports timeout
            bus.timeout <= at_max & ~bus.done & held;
          end else begin
            // rel covers at_max, so this never passes HOLD_MAX
            hold        <= hold + 8'd1;
            bus.timeout <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
